// File: rtl/fifo_write_arbiter_if.sv
// Bundle of requester, FIFO and consumer signals around the shared-FIFO write arbiter.
// The master side drives requests and FIFO status; the slave side is the arbiter.
interface fifo_write_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0][W-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   fifo_write_en;
    logic [W-1:0]           fifo_write_data;
    logic [SW-1:0]          fifo_wr_src;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   deq_req;
    logic                   fifo_read_en;
    logic                   flush;
    logic                   flush_done;
    logic                   busy;
    logic [15:0]            grant_count;

    modport master (
        output req, req_data, fifo_full, fifo_empty, deq_req, flush,
        input  gnt, fifo_write_en, fifo_write_data, fifo_wr_src,
               fifo_read_en, flush_done, busy, grant_count
    );

    modport slave (
        input  req, req_data, fifo_full, fifo_empty, deq_req, flush,
        output gnt, fifo_write_en, fifo_write_data, fifo_wr_src,
               fifo_read_en, flush_done, busy, grant_count
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter feeding one shared FIFO from NREQ requesters, with a
// RUN/FLUSH controller that drains the FIFO on request.
module fifo_write_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    fifo_write_arbiter_if.slave bus
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_rr_ptr;
    logic [15:0]     r_grant_count;
    logic            r_flush_done;
    logic            r_busy;

    logic            w_can_write;
    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_req_hi;
    logic [NREQ-1:0] w_gnt;
    logic [SW-1:0]   w_src;
    logic [W-1:0]    w_wdata;
    logic            w_write_en;
    logic            w_read_en;

    function automatic logic [NREQ-1:0] lowest_first(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] onehot;
        onehot = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
        return onehot;
    endfunction

    function automatic logic [SW-1:0] onehot_index(input logic [NREQ-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_mask[i] = (SW'(i) >= r_rr_ptr);
        end
    end

    assign w_can_write = !reset && (r_state == RUN) && !bus.flush && !bus.fifo_full;
    assign w_req_hi    = bus.req & w_mask;
    assign w_gnt       = !w_can_write ? '0 :
                         (|w_req_hi)  ? lowest_first(w_req_hi) : lowest_first(bus.req);
    assign w_src       = onehot_index(w_gnt);
    assign w_write_en  = |w_gnt;

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_wdata = w_wdata | bus.req_data[i];
        end
    end

    // While flushing, the FIFO drains on its own and the consumer request is ignored.
    assign w_read_en = !reset && !bus.fifo_empty && ((r_state == FLUSH) || bus.deq_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_rr_ptr      <= '0;
            r_grant_count <= '0;
            r_flush_done  <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            if (w_write_en) begin
                r_rr_ptr      <= (w_src == SW'(NREQ - 1)) ? '0 : w_src + SW'(1);
                r_grant_count <= r_grant_count + 16'd1;
            end
            case (r_state)
                RUN: begin
                    if (bus.flush) begin
                        r_state <= FLUSH;
                        r_busy  <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (bus.fifo_empty) begin
                        r_state      <= RUN;
                        r_busy       <= 1'b0;
                        r_flush_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt             = w_gnt;
    assign bus.fifo_write_en   = w_write_en;
    assign bus.fifo_write_data = w_wdata;
    assign bus.fifo_wr_src     = w_src;
    assign bus.fifo_read_en    = w_read_en;
    assign bus.flush_done      = r_flush_done;
    assign bus.busy            = r_busy;
    assign bus.grant_count     = r_grant_count;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed and randomized bench for fifo_write_arbiter, compared each cycle
// against a behavioural model of the arbitration and flush rules.
module tb_fifo_write_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    fifo_write_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit m_flush;
    bit m_done;
    int m_rr;
    int m_cnt;

    logic [NREQ-1:0] last_gnt;
    logic            last_re;
    logic            last_busy;
    logic            last_done;
    logic [15:0]     last_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        int g;
        g = -1;
        if (!reset && !m_flush && !bus.flush && !bus.fifo_full) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (g < 0 && bus.req[j]) g = j;
            end
        end
        return g;
    endfunction

    task automatic drive(input logic rst, input logic [NREQ-1:0] rq, input logic full,
                         input logic emp, input logic deq, input logic fl);
        reset          = rst;
        bus.req        = rq;
        bus.fifo_full  = full;
        bus.fifo_empty = emp;
        bus.deq_req    = deq;
        bus.flush      = fl;
        for (int i = 0; i < NREQ; i++) bus.req_data[i] = $urandom();
    endtask

    // Check outputs mid-cycle, then advance the model across the rising edge.
    task automatic tick();
        int              g;
        logic [NREQ-1:0] eg;
        logic [W-1:0]    ed;
        logic            ere;
        @(negedge clk);
        g  = exp_grant();
        eg = '0;
        ed = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i == g) begin
                eg[i] = 1'b1;
                ed    = bus.req_data[i];
            end
        end
        ere = !reset && !bus.fifo_empty && (m_flush || bus.deq_req);
        chk("gnt",         32'(bus.gnt),             32'(eg));
        chk("write_en",    32'(bus.fifo_write_en),   32'(g >= 0));
        chk("write_data",  32'(bus.fifo_write_data), 32'(ed));
        chk("wr_src",      32'(bus.fifo_wr_src),     (g >= 0) ? g : 0);
        chk("read_en",     32'(bus.fifo_read_en),    32'(ere));
        chk("busy",        32'(bus.busy),            32'(m_flush));
        chk("flush_done",  32'(bus.flush_done),      32'(m_done));
        chk("grant_count", 32'(bus.grant_count),     m_cnt);
        last_gnt  = bus.gnt;
        last_re   = bus.fifo_read_en;
        last_busy = bus.busy;
        last_done = bus.flush_done;
        last_cnt  = bus.grant_count;
        @(posedge clk);
        if (reset) begin
            m_flush = 1'b0;
            m_done  = 1'b0;
            m_rr    = 0;
            m_cnt   = 0;
        end else begin
            m_done = m_flush && bus.fifo_empty;
            if (g >= 0) begin
                m_rr  = (g + 1) % NREQ;
                m_cnt = (m_cnt + 1) % 65536;
            end
            if (m_flush) begin
                if (bus.fifo_empty) m_flush = 1'b0;
            end else if (bus.flush) begin
                m_flush = 1'b1;
            end
        end
        #1;
    endtask

    initial begin
        int occ;
        int reads;
        int dones;
        int busy_cyc;

        m_flush = 1'b0;
        m_done  = 1'b0;
        m_rr    = 0;
        m_cnt   = 0;

        // Reset overrides requests, flush and reads in the same cycle.
        drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        tick();
        tick();

        // Fairness: all requesting rotates through every index.
        drive(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            chk("fair_gnt", 32'(last_gnt), 32'(1) << (i % 4));
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("fair_count", 32'(last_cnt), 32'd8);

        // Skip: pointer at 1 with only requester 0 asking.
        drive(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("skip_gnt0", 32'(last_gnt), 32'b0001);
        drive(1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("skip_gnt3", 32'(last_gnt), 32'b1000);

        // Full back-pressure holds the pointer.
        drive(1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("full_gnt_a", 32'(last_gnt), 32'b0000);
        tick();
        chk("full_gnt_b", 32'(last_gnt), 32'b0000);
        drive(1'b0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("unfull_gnt", 32'(last_gnt), 32'b0010);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 63) == 0), NREQ'($urandom()),
                  logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 2) == 0),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0));
            tick();
        end

        // Flush with three queued entries; deq_req and a second flush are ignored.
        drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        occ = 3;
        drive(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        reads    = 0;
        dones    = 0;
        busy_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'b1111, 1'b0, logic'(occ == 0), logic'(i % 2), logic'(i == 1));
            tick();
            if (last_busy) begin
                busy_cyc++;
                if (last_re) begin
                    reads++;
                    occ--;
                end
            end
            if (last_done) dones++;
        end
        chk("flush3_reads", 32'(reads), 32'd3);
        chk("flush3_busy", 32'(busy_cyc), 32'd4);
        chk("flush3_done", 32'(dones), 32'd1);

        // Flush of an already-empty FIFO.
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        reads    = 0;
        dones    = 0;
        busy_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            if (last_busy) busy_cyc++;
            if (last_re) reads++;
            if (last_done) dones++;
        end
        chk("flush0_busy", 32'(busy_cyc), 32'd1);
        chk("flush0_reads", 32'(reads), 32'd0);
        chk("flush0_done", 32'(dones), 32'd1);

        // Reset in the middle of a flush.
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("midflush_busy", 32'(last_busy), 32'd1);
        drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("rstflush_busy", 32'(last_busy), 32'd0);
        chk("rstflush_gnt", 32'(last_gnt), 32'b0001);

        // Grant counter wrap.
        drive(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("wrap_pre", 32'(last_cnt), 32'hFFFF);
        drive(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("wrap_post", 32'(last_cnt), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
